// File: rtl/ads1115_scan_sequencer.sv
// ADS1115 scan sequencer: drives the i2c_master request port through a periodic
// single-shot scan of NUM_CH single-ended channels and publishes signed results.
module ads1115_scan_sequencer #(
  parameter int unsigned NUM_CH         = 4,
  parameter logic [6:0]  SLAVE_ADDR     = 7'h48,
  parameter logic [2:0]  PGA            = 3'b010,
  parameter logic [2:0]  DR             = 3'b100,
  parameter int unsigned CONV_CYCLES    = 1_000_000,
  parameter int unsigned PERIOD_CYCLES  = 12_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_i,
  output logic               i2c_start_o,
  output logic               i2c_rd_nwr_o,
  output logic [6:0]         i2c_slave_addr_o,
  output logic [7:0]         i2c_din_o [3],
  output logic [1:0]         i2c_bytes_num_o,
  input  logic [7:0]         i2c_dout_i [3],
  input  logic               i2c_done_i,
  input  logic               i2c_error_i,
  output logic signed [15:0] ch_data_o [NUM_CH],
  output logic               ch_valid_o,
  output logic [1:0]         ch_idx_o,
  output logic               scan_done_o,
  output logic               busy_o,
  output logic [7:0]         err_count_o
);

  localparam logic [31:0] CONV_LAST    = 32'(CONV_CYCLES - 1);
  localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  CH_LAST      = 2'(NUM_CH - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_CFG_W, S_CONV, S_PTR, S_PTR_W, S_RD, S_RD_W, S_STORE, S_PERIOD
  } state_t;

  state_t      state_q;
  logic [1:0]  ch_q;
  logic [31:0] wait_q;
  logic [31:0] period_q;
  logic        fail_q;
  logic [15:0] rd_data_q;

  logic [7:0]  cfg_msb_s;
  logic [7:0]  cfg_lsb_s;
  logic        timed_out_s;
  logic        period_hit_s;
  logic        unused_dout_s;

  // Config word: OS=1, MUX=1xx (AINx vs GND), PGA, single-shot; DR, comparator disabled.
  assign cfg_msb_s        = {1'b1, 1'b1, ch_q, PGA, 1'b1};
  assign cfg_lsb_s        = {DR, 5'b00011};
  assign timed_out_s      = (wait_q == TIMEOUT_LAST);
  assign period_hit_s     = (period_q >= PERIOD_LAST);
  assign i2c_slave_addr_o = SLAVE_ADDR;
  assign busy_o           = (state_q != S_IDLE);
  assign unused_dout_s    = ^i2c_dout_i[2];

  // Scan state machine with all request and result outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      ch_q            <= 2'd0;
      wait_q          <= 32'd0;
      period_q        <= 32'd0;
      fail_q          <= 1'b0;
      rd_data_q       <= 16'h0000;
      i2c_start_o     <= 1'b0;
      i2c_rd_nwr_o    <= 1'b0;
      i2c_din_o[0]    <= 8'h00;
      i2c_din_o[1]    <= 8'h00;
      i2c_din_o[2]    <= 8'h00;
      i2c_bytes_num_o <= 2'd0;
      for (int i = 0; i < NUM_CH; i++) ch_data_o[i] <= 16'sd0;
      ch_valid_o      <= 1'b0;
      ch_idx_o        <= 2'd0;
      scan_done_o     <= 1'b0;
      err_count_o     <= 8'd0;
    end else begin
      i2c_start_o <= 1'b0;
      ch_valid_o  <= 1'b0;
      scan_done_o <= 1'b0;
      if (period_q != 32'hFFFF_FFFF) period_q <= period_q + 32'd1;

      case (state_q)
        S_IDLE: begin
          period_q <= 32'd0;
          ch_q     <= 2'd0;
          if (enable_i) state_q <= S_CFG;
        end
        S_CFG: begin
          i2c_start_o     <= 1'b1;
          i2c_rd_nwr_o    <= 1'b0;
          i2c_bytes_num_o <= 2'd3;
          i2c_din_o[0]    <= 8'h01;
          i2c_din_o[1]    <= cfg_msb_s;
          i2c_din_o[2]    <= cfg_lsb_s;
          ch_idx_o        <= ch_q;
          fail_q          <= 1'b0;
          wait_q          <= 32'd0;
          // Counter reads 1 in the cycle after a scan start so that starts land PERIOD apart.
          if (ch_q == 2'd0) period_q <= 32'd1;
          state_q <= S_CFG_W;
        end
        S_CFG_W: begin
          if (i2c_done_i) begin
            wait_q <= 32'd0;
            if (i2c_error_i) begin
              fail_q  <= 1'b1;
              state_q <= S_STORE;
            end else begin
              state_q <= S_CONV;
            end
          end else if (timed_out_s) begin
            fail_q  <= 1'b1;
            state_q <= S_STORE;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        S_CONV: begin
          if (wait_q == CONV_LAST) state_q <= S_PTR;
          else wait_q <= wait_q + 32'd1;
        end
        S_PTR: begin
          i2c_start_o     <= 1'b1;
          i2c_rd_nwr_o    <= 1'b0;
          i2c_bytes_num_o <= 2'd1;
          i2c_din_o[0]    <= 8'h00;
          wait_q          <= 32'd0;
          state_q         <= S_PTR_W;
        end
        S_PTR_W: begin
          if (i2c_done_i) begin
            fail_q  <= i2c_error_i;
            state_q <= i2c_error_i ? S_STORE : S_RD;
          end else if (timed_out_s) begin
            fail_q  <= 1'b1;
            state_q <= S_STORE;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        S_RD: begin
          i2c_start_o     <= 1'b1;
          i2c_rd_nwr_o    <= 1'b1;
          i2c_bytes_num_o <= 2'd2;
          wait_q          <= 32'd0;
          state_q         <= S_RD_W;
        end
        S_RD_W: begin
          if (i2c_done_i) begin
            fail_q    <= i2c_error_i;
            rd_data_q <= {i2c_dout_i[0], i2c_dout_i[1]};
            state_q   <= S_STORE;
          end else if (timed_out_s) begin
            fail_q  <= 1'b1;
            state_q <= S_STORE;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        S_STORE: begin
          if (fail_q) begin
            if (err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
          end else begin
            ch_data_o[ch_q] <= rd_data_q;
            ch_valid_o      <= 1'b1;
          end
          if (ch_q != CH_LAST) begin
            ch_q    <= ch_q + 2'd1;
            state_q <= enable_i ? S_CFG : S_IDLE;
          end else begin
            ch_q        <= 2'd0;
            scan_done_o <= 1'b1;
            if (!enable_i) state_q <= S_IDLE;
            else if (period_hit_s) state_q <= S_CFG;
            else state_q <= S_PERIOD;
          end
        end
        S_PERIOD: begin
          if (!enable_i) state_q <= S_IDLE;
          else if (period_hit_s) state_q <= S_CFG;
          else state_q <= S_PERIOD;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
